// File: rtl/c28soi_pm_control_jtag_pkg.sv
// Shared definitions for the PM controller JTAG data registers:
// capture-source encodings and a constant-evaluable ceil(log2) helper.
package c28soi_pm_control_jtag_pkg;

    localparam int CAP_ZERO     = 0;
    localparam int CAP_EXT      = 1;
    localparam int CAP_READBACK = 2;

    // Smallest r with 2**r >= n; usable in parameter expressions.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/c28soi_pm_control_jtag_len_cnt.sv
// Saturating shift-length counter for a JTAG data register; reports when
// exactly WIDTH shifts have happened since the last clear.
module c28soi_pm_control_jtag_len_cnt
    import c28soi_pm_control_jtag_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CW    = clog2(WIDTH + 2)
) (
    input  logic reg_tck,
    input  logic reg_rst_n,
    input  logic clr,
    input  logic inc,
    output logic eq_width
);

    localparam logic [CW-1:0] CNT_SAT = CW'(WIDTH + 1);
    localparam logic [CW-1:0] CNT_LEN = CW'(WIDTH);

    logic [CW-1:0] cnt;

    // Stops at WIDTH+1 so any over-shift stays distinguishable from WIDTH.
    always_ff @(posedge reg_tck or negedge reg_rst_n) begin
        if (!reg_rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != CNT_SAT)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign eq_width = (cnt == CNT_LEN);

endmodule

// File: rtl/c28soi_pm_control_jtag_tdr.sv
// WIDTH-bit JTAG test data register: capture/shift stage, shadow update stage
// with a one-cycle update pulse and optional shift-length checking.
module c28soi_pm_control_jtag_tdr
    import c28soi_pm_control_jtag_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VAL   = '0,
    parameter int               CAPTURE_SRC = 1,
    parameter int               STRICT_LEN  = 1
) (
    input  logic             reg_tck,
    input  logic             reg_rst_n,
    input  logic             reg_tdi,
    input  logic             reg_select,
    input  logic             reg_capture_en,
    input  logic             reg_shift_enable,
    input  logic             reg_update_en,
    input  logic [WIDTH-1:0] reg_capture_data,
    output logic             reg_tdo,
    output logic [WIDTH-1:0] reg_update_data,
    output logic             reg_update_pulse,
    output logic             reg_len_err
);

    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] update_q;
    logic [WIDTH-1:0] shift_nxt;
    logic [WIDTH-1:0] capture_val;
    logic             pulse_q;
    logic             err_q;
    logic             do_capture;
    logic             do_shift;
    logic             do_update;
    logic             upd_ok;
    logic             eq_width;

    // One action per edge: capture beats shift beats update.
    assign do_capture = reg_select & reg_capture_en;
    assign do_shift   = reg_select & ~reg_capture_en & reg_shift_enable;
    assign do_update  = reg_select & ~reg_capture_en & ~reg_shift_enable & reg_update_en;
    assign upd_ok     = (STRICT_LEN == 0) | eq_width;

    always_comb begin
        capture_val = '0;
        case (CAPTURE_SRC)
            CAP_EXT:      capture_val = reg_capture_data;
            CAP_READBACK: capture_val = update_q;
            default:      capture_val = '0;
        endcase
    end

    // Written as shift-then-overwrite so WIDTH=1 needs no empty slice.
    always_comb begin
        shift_nxt            = shift_q >> 1;
        shift_nxt[WIDTH-1]   = reg_tdi;
    end

    always_ff @(posedge reg_tck or negedge reg_rst_n) begin
        if (!reg_rst_n) begin
            shift_q <= RESET_VAL;
        end else if (do_capture) begin
            shift_q <= capture_val;
        end else if (do_shift) begin
            shift_q <= shift_nxt;
        end
    end

    always_ff @(posedge reg_tck or negedge reg_rst_n) begin
        if (!reg_rst_n) begin
            update_q <= RESET_VAL;
        end else if (do_update && upd_ok) begin
            update_q <= shift_q;
        end
    end

    always_ff @(posedge reg_tck or negedge reg_rst_n) begin
        if (!reg_rst_n) begin
            pulse_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            pulse_q <= do_update & upd_ok;
            if (do_capture) begin
                err_q <= 1'b0;
            end else if (do_update && !upd_ok) begin
                err_q <= 1'b1;
            end
        end
    end

    c28soi_pm_control_jtag_len_cnt #(
        .WIDTH (WIDTH)
    ) u_len_cnt (
        .reg_tck   (reg_tck),
        .reg_rst_n (reg_rst_n),
        .clr       (do_capture),
        .inc       (do_shift),
        .eq_width  (eq_width)
    );

    assign reg_tdo          = shift_q[0];
    assign reg_update_data  = update_q;
    assign reg_update_pulse = pulse_q;
    assign reg_len_err      = err_q;

endmodule

// File: tb/tb_c28soi_pm_control_jtag_tdr.sv
// Bench for the JTAG TDR: four configurations driven in parallel, checked
// every cycle against a behavioural model plus literal test-plan values.
module tb_c28soi_pm_control_jtag_tdr;

    logic       tck = 1'b0;
    logic       rst_n = 1'b0;
    logic       tdi = 1'b0;
    logic       sel = 1'b0;
    logic       cap = 1'b0;
    logic       shf = 1'b0;
    logic       upd = 1'b0;
    logic [7:0] cd = 8'h3C;

    logic       tdo_a, tdo_b, tdo_c, tdo_d;
    logic [7:0] upd_a, upd_b, upd_c;
    logic       upd_d;
    logic       pls_a, pls_b, pls_c, pls_d;
    logic       err_a, err_b, err_c, err_d;

    int total = 0;
    int bad   = 0;

    always #5 tck = ~tck;

    // a: strict, external capture, reset A5; b: lenient; c: readback; d: bypass
    c28soi_pm_control_jtag_tdr #(.WIDTH(8), .RESET_VAL(8'hA5), .CAPTURE_SRC(1), .STRICT_LEN(1)) dut_a (
        .reg_tck(tck), .reg_rst_n(rst_n), .reg_tdi(tdi), .reg_select(sel),
        .reg_capture_en(cap), .reg_shift_enable(shf), .reg_update_en(upd),
        .reg_capture_data(cd), .reg_tdo(tdo_a), .reg_update_data(upd_a),
        .reg_update_pulse(pls_a), .reg_len_err(err_a));

    c28soi_pm_control_jtag_tdr #(.WIDTH(8), .RESET_VAL(8'h00), .CAPTURE_SRC(1), .STRICT_LEN(0)) dut_b (
        .reg_tck(tck), .reg_rst_n(rst_n), .reg_tdi(tdi), .reg_select(sel),
        .reg_capture_en(cap), .reg_shift_enable(shf), .reg_update_en(upd),
        .reg_capture_data(cd), .reg_tdo(tdo_b), .reg_update_data(upd_b),
        .reg_update_pulse(pls_b), .reg_len_err(err_b));

    c28soi_pm_control_jtag_tdr #(.WIDTH(8), .RESET_VAL(8'h00), .CAPTURE_SRC(2), .STRICT_LEN(1)) dut_c (
        .reg_tck(tck), .reg_rst_n(rst_n), .reg_tdi(tdi), .reg_select(sel),
        .reg_capture_en(cap), .reg_shift_enable(shf), .reg_update_en(upd),
        .reg_capture_data(cd), .reg_tdo(tdo_c), .reg_update_data(upd_c),
        .reg_update_pulse(pls_c), .reg_len_err(err_c));

    c28soi_pm_control_jtag_tdr #(.WIDTH(1), .RESET_VAL(1'b0), .CAPTURE_SRC(0), .STRICT_LEN(0)) dut_d (
        .reg_tck(tck), .reg_rst_n(rst_n), .reg_tdi(tdi), .reg_select(sel),
        .reg_capture_en(cap), .reg_shift_enable(shf), .reg_update_en(upd),
        .reg_capture_data(cd[0]), .reg_tdo(tdo_d), .reg_update_data(upd_d),
        .reg_update_pulse(pls_d), .reg_len_err(err_d));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int         p_w[4]      = '{8, 8, 8, 1};
    int         p_src[4]    = '{1, 1, 2, 0};
    int         p_strict[4] = '{1, 0, 1, 0};
    logic [7:0] p_rst[4]    = '{8'hA5, 8'h00, 8'h00, 8'h00};

    logic [7:0] m_sh[4];
    logic [7:0] m_up[4];
    int         m_cnt[4];
    logic       m_pulse[4];
    logic       m_err[4];

    always @(posedge tck or negedge rst_n) begin
        for (int i = 0; i < 4; i++) begin
            logic [7:0] mask;
            logic [7:0] tin;
            mask = (p_w[i] == 8) ? 8'hFF : 8'h01;
            tin  = {7'b0, tdi} << (p_w[i] - 1);
            if (!rst_n) begin
                m_sh[i] = p_rst[i]; m_up[i] = p_rst[i];
                m_cnt[i] = 0; m_pulse[i] = 1'b0; m_err[i] = 1'b0;
            end else begin
                m_pulse[i] = 1'b0;
                if (sel && cap) begin
                    m_sh[i]  = (p_src[i] == 1) ? (cd & mask) : (p_src[i] == 2) ? m_up[i] : 8'h00;
                    m_cnt[i] = 0;
                    m_err[i] = 1'b0;
                end else if (sel && shf) begin
                    m_sh[i]  = ((m_sh[i] >> 1) | tin) & mask;
                    m_cnt[i] = (m_cnt[i] + 1 > p_w[i] + 1) ? p_w[i] + 1 : m_cnt[i] + 1;
                end else if (sel && upd) begin
                    if (p_strict[i] == 0 || m_cnt[i] == p_w[i]) begin
                        m_up[i] = m_sh[i];
                        m_pulse[i] = 1'b1;
                    end else begin
                        m_err[i] = 1'b1;
                    end
                end
            end
        end
    end

    // Outputs depend only on state, so the falling edge is a stable point.
    always @(negedge tck) begin
        logic       o_tdo[4];
        logic [7:0] o_upd[4];
        logic       o_pls[4];
        logic       o_err[4];
        o_tdo = '{tdo_a, tdo_b, tdo_c, tdo_d};
        o_upd = '{upd_a, upd_b, upd_c, {7'b0, upd_d}};
        o_pls = '{pls_a, pls_b, pls_c, pls_d};
        o_err = '{err_a, err_b, err_c, err_d};
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("model_tdo[%0d]", i), 64'(o_tdo[i]), 64'(m_sh[i][0]));
            chk($sformatf("model_upd[%0d]", i), 64'(o_upd[i]), 64'(m_up[i]));
            chk($sformatf("model_pulse[%0d]", i), 64'(o_pls[i]), 64'(m_pulse[i]));
            chk($sformatf("model_err[%0d]", i), 64'(o_err[i]), 64'(m_err[i]));
        end
    end

    // ---------------- driver ----------------
    task automatic op(input logic s, input logic c, input logic sh, input logic u, input logic t);
        sel = s; cap = c; shf = sh; upd = u; tdi = t;
        @(posedge tck);
        @(negedge tck);
    endtask

    initial begin
        logic [7:0] seq_3c;
        logic [7:0] seq_5a;
        logic [8:0] pat9;
        seq_3c = 8'h3C;
        seq_5a = 8'h5A;
        pat9   = 9'b1_1000_0110;   // sent bit 0 first; the last eight form C3

        @(negedge tck);
        @(negedge tck);
        #1 rst_n = 1'b1;
        @(negedge tck);
        chk("reset_upd", 64'(upd_a), 64'h A5);
        chk("reset_tdo", 64'(tdo_a), 64'h1);
        chk("reset_pulse", 64'(pls_a), 64'h0);
        chk("reset_err", 64'(err_a), 64'h0);

        op(1, 1, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("tdo_3c_bit%0d", i), 64'(tdo_a), 64'(seq_3c[i]));
            op(1, 0, 1, 0, 1);
        end
        op(1, 0, 0, 1, 0);
        chk("upd_ff", 64'(upd_a), 64'hFF);
        chk("pulse_on", 64'(pls_a), 64'h1);
        op(0, 0, 0, 0, 0);
        chk("pulse_one_cycle", 64'(pls_a), 64'h0);

        op(1, 1, 0, 0, 0);
        for (int i = 0; i < 7; i++) op(1, 0, 1, 0, 0);
        op(1, 0, 0, 1, 0);
        chk("short_upd_held", 64'(upd_a), 64'hFF);
        chk("short_err", 64'(err_a), 64'h1);
        chk("short_no_pulse", 64'(pls_a), 64'h0);
        op(1, 1, 0, 0, 0);
        chk("capture_clears_err", 64'(err_a), 64'h0);

        for (int i = 0; i < 9; i++) op(1, 0, 1, 0, pat9[i]);
        op(1, 0, 0, 1, 0);
        chk("long_err_strict", 64'(err_a), 64'h1);
        chk("long_upd_strict", 64'(upd_a), 64'hFF);
        chk("long_upd_lenient", 64'(upd_b), 64'hC3);
        chk("long_pulse_lenient", 64'(pls_b), 64'h1);

        op(1, 1, 0, 0, 0);
        for (int i = 0; i < 8; i++) op(1, 0, 1, 0, seq_5a[i]);
        op(1, 0, 0, 1, 0);
        chk("readback_load", 64'(upd_c), 64'h5A);
        op(1, 1, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("tdo_5a_bit%0d", i), 64'(tdo_c), 64'(seq_5a[i]));
            op(1, 0, 1, 0, 0);
        end

        op(1, 1, 1, 1, 1);
        chk("all_en_tdo", 64'(tdo_c), 64'h0);
        chk("all_en_pulse", 64'(pls_c), 64'h0);
        chk("all_en_upd", 64'(upd_c), 64'h5A);
        op(1, 0, 1, 1, 1);
        chk("shift_beats_upd_err", 64'(err_a), 64'h0);
        chk("shift_beats_upd_pulse", 64'(pls_a), 64'h0);

        op(0, 1, 0, 0, 1);
        op(0, 0, 1, 0, 1);
        op(0, 0, 0, 1, 0);
        op(0, 1, 1, 1, 1);
        chk("unsel_upd", 64'(upd_a), 64'h5A);
        chk("unsel_tdo", 64'(tdo_a), 64'h0);
        chk("unsel_err", 64'(err_a), 64'h0);

        op(1, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) op(1, 0, 1, 0, 1);
        sel = 1; cap = 0; shf = 0; upd = 1; tdi = 0;
        #2 rst_n = 1'b0;
        @(posedge tck);
        @(negedge tck);
        chk("midreset_upd", 64'(upd_a), 64'hA5);
        chk("midreset_tdo", 64'(tdo_a), 64'h1);
        chk("midreset_pulse", 64'(pls_a), 64'h0);
        #1 rst_n = 1'b1;
        @(negedge tck);
        op(1, 0, 0, 1, 0);
        chk("post_reset_no_pulse", 64'(pls_a), 64'h0);
        chk("post_reset_upd", 64'(upd_a), 64'hA5);
        op(0, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
